serial_parity_frame_checker: RTL and testbench
==============================================

// Module: serial_parity_frame_checker
// PURPOSE
//  - Consumes the serial bit stream from the XOR/parity datapath and checks framed words.
//  - Frame = DATA_BITS data bits (LSB first) followed by 1 parity bit.
//  - Deserialises the word, XOR-accumulates the bits, compares against the parity bit and
//    presents {word, ok} on a valid/ready output.
// PARAMETERS
//  DATA_BITS   8  data bits per frame, >= 2
//  ODD_PARITY  0  0: even parity (XOR of data ^ parity bit == 0 means ok); 1: odd (== 1 means ok)
// PORTS
//  clk        in   1          clock, all state on posedge
//  rst_n      in   1          asynchronous active-low reset
//  frame_clr  in   1          sync abort of the frame in progress
//  in_valid   in   1          in_bit valid this cycle
//  in_ready   out  1          checker accepts in_bit this cycle
//  in_bit     in   1          serial data or parity bit
//  out_valid  out  1          result pending
//  out_ready  in   1          downstream takes result
//  out_data   out  DATA_BITS  deserialised word, bit0 = first received
//  out_ok     out  1          1 = parity matched
//  `ifdef PARITY_ERR_COUNT_EN
//  err_count  out  16         saturating count of failed frames
//  `endif
// BEHAVIOUR
//  - Reset (rst_n low, async): state=S_DATA, bit counter=0, acc=0, shift reg=0,
//    out_valid=0, out_ok=0, out_data=0, in_ready=1 after release, err_count=0.
//  - Input beat accepted iff in_valid && in_ready; in_ready = (state != S_HOLD).
//  - S_DATA: on a beat, shift in_bit into shift reg at index cnt, acc <= acc ^ in_bit, cnt++.
//    When the beat at cnt==DATA_BITS-1 is taken -> S_PARITY, cnt <= 0.
//  - S_PARITY: on a beat, ok = ((acc ^ in_bit) == ODD_PARITY); latch out_data, out_ok;
//    out_valid <= 1; -> S_HOLD. Result visible the cycle after the parity beat (latency 1).
//  - S_HOLD: out_valid held, out_data/out_ok stable until out_valid && out_ready;
//    then out_valid <= 0, acc <= 0, -> S_DATA. in_ready is low the whole time (no overlap);
//    in_ready rises the cycle after the handshake.
//  - out_ready is ignored when out_valid=0; in_valid is ignored when in_ready=0.
//  - frame_clr: in S_DATA/S_PARITY it drops the partial frame (cnt=0, acc=0, ->S_DATA) and
//    wins over a simultaneous beat; in S_HOLD it has no effect (a produced result is never lost).
//  - Counter width $clog2(DATA_BITS); never exceeds DATA_BITS-1, no wrap beyond frame.
//  - Continuous in_valid=1 gives 1 frame per DATA_BITS+1 beats plus hold time.
// CONFIGURATION
//  - PARITY_ERR_COUNT_EN defined: err_count increments by 1 on each output handshake with
//    out_ok=0, saturates at 16'hFFFF, cleared only by rst_n (not frame_clr).
//  - Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package parity_checker_pkg: state_e enum {S_DATA, S_PARITY, S_HOLD} (2-bit),
//    localparam ERR_CNT_W = 16.
//  - Sub-module parity_step: combinational acc_next = acc ^ bit_in (1-bit), instanced once
//    for the accumulator; the top module holds the FSM, counter, shift reg and output regs.
// TESTING  (DATA_BITS=8, ODD_PARITY=0 unless stated)
//  - Bits of 8'hA5 LSB first, parity 0, out_ready=1 -> out_valid 1 cycle, out_data=8'hA5, out_ok=1.
//  - Bits of 8'h07, parity 0 -> out_ok=0; with PARITY_ERR_COUNT_EN, err_count 0->1.
//  - 8'h3C + parity 0, out_ready=0 for 5 cycles -> out_valid/out_data stable, in_ready=0,
//    in_valid beats ignored; accepted on out_ready=1, next frame decodes correctly.
//  - frame_clr after 4 data bits, then full 8'hFF + parity 0 -> single result 8'hFF, ok=1.
//  - rst_n low mid-frame (after 3 bits) -> outputs zero immediately; next full frame correct.
//  - ODD_PARITY=1: 8'h01 + parity 0 -> ok=1; 8'h01 + parity 1 -> ok=0.

Source files
------------

// File: rtl/parity_checker_pkg.sv
// rtl/parity_checker_pkg.sv - shared types and constants for the serial parity frame checker
//
// Contents:
//   state_e    frame FSM state: collecting data, awaiting parity, holding result
//   ERR_CNT_W  width of the optional failed-frame counter
package parity_checker_pkg;

  typedef enum logic [1:0] {
    S_DATA   = 2'd0,
    S_PARITY = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/parity_step.sv
// rtl/parity_step.sv - one-bit parity accumulator step
//
// Ports:
//   acc       in   running XOR of the bits seen so far
//   bit_in    in   incoming serial bit
//   acc_next  out  accumulator value after absorbing bit_in
module parity_step (
  input  logic acc,
  input  logic bit_in,
  output logic acc_next
);

  assign acc_next = acc ^ bit_in;

endmodule

// File: rtl/serial_parity_frame_checker.sv
// rtl/serial_parity_frame_checker.sv - deserialises LSB-first framed words and checks their parity bit
//
// Optional feature macro: PARITY_ERR_COUNT_EN (adds err_count).
//
// Ports:
//   clk        in   clock, all state on posedge
//   rst_n      in   asynchronous active-low reset
//   frame_clr  in   synchronous abort of the frame in progress (no effect while a result is held)
//   in_valid   in   in_bit valid this cycle
//   in_ready   out  checker accepts in_bit this cycle (low while a result is held)
//   in_bit     in   serial data or parity bit
//   out_valid  out  result pending
//   out_ready  in   downstream takes the result
//   out_data   out  deserialised word, bit0 = first received
//   out_ok     out  1 = parity matched
//   err_count  out  saturating count of failed frames handed off (PARITY_ERR_COUNT_EN only)
module serial_parity_frame_checker
  import parity_checker_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_bit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_ok
`ifdef PARITY_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);
  // Value the XOR of data and parity bit must take for the frame to be good.
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  logic                 acc;
  logic                 acc_next;
  logic [DATA_BITS-1:0] shift_reg;

  parity_step u_parity_step (
    .acc      (acc),
    .bit_in   (in_bit),
    .acc_next (acc_next)
  );

  // Input is refused only while a result waits for the downstream; this
  // keeps a produced result from ever being overwritten.
  assign in_ready = (state != S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_DATA;
      cnt       <= '0;
      acc       <= 1'b0;
      shift_reg <= '0;
      out_valid <= 1'b0;
      out_ok    <= 1'b0;
      out_data  <= '0;
`ifdef PARITY_ERR_COUNT_EN
      err_count <= '0;
`endif
    end else begin
      case (state)
        S_DATA: begin
          // frame_clr outranks a beat arriving in the same cycle.
          if (frame_clr) begin
            cnt <= '0;
            acc <= 1'b0;
          end else if (in_valid) begin
            shift_reg[cnt] <= in_bit;
            acc            <= acc_next;
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= S_PARITY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (frame_clr) begin
            cnt   <= '0;
            acc   <= 1'b0;
            state <= S_DATA;
          end else if (in_valid) begin
            out_data  <= shift_reg;
            out_ok    <= (acc_next == ODD_BIT);
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= 1'b0;
            state     <= S_DATA;
`ifdef PARITY_ERR_COUNT_EN
            if (!out_ok && (err_count != '1)) begin
              err_count <= err_count + ERR_CNT_W'(1);
            end
`endif
          end
        end
        default: begin
          state <= S_DATA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_parity_frame_checker.sv
// tb/tb_serial_parity_frame_checker.sv - self-checking bench for serial_parity_frame_checker
module tb_serial_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_clr;
  logic       in_valid;
  logic       in_bit;
  logic       out_ready;
  logic       in_ready,  in_ready_odd;
  logic       out_valid, out_valid_odd;
  logic [7:0] out_data,  out_data_odd;
  logic       out_ok,    out_ok_odd;
`ifdef PARITY_ERR_COUNT_EN
  logic [15:0] err_count, err_count_odd;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_clr (frame_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ok    (out_ok)
`ifdef PARITY_ERR_COUNT_EN
    ,
    .err_count (err_count)
`endif
  );

  serial_parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(1)) dut_odd (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_clr (frame_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready_odd),
    .in_bit    (in_bit),
    .out_valid (out_valid_odd),
    .out_ready (out_ready),
    .out_data  (out_data_odd),
    .out_ok    (out_ok_odd)
`ifdef PARITY_ERR_COUNT_EN
    ,
    .err_count (err_count_odd)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a list of received data bits; the result is the word
  // those bits spell and whether the total number of ones (data + parity)
  // is even (even checker) or odd (odd checker).
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ok_even;
  bit         m_ok_odd;
  int         m_errs_even;
  int         m_errs_odd;
  bit         m_bits[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid     = 1'b0;
      m_data      = 8'h00;
      m_ok_even   = 1'b0;
      m_ok_odd    = 1'b0;
      m_errs_even = 0;
      m_errs_odd  = 0;
      m_bits.delete();
    end else if (m_valid) begin
      if (out_ready) begin
        if (!m_ok_even && m_errs_even < 65535) m_errs_even++;
        if (!m_ok_odd && m_errs_odd < 65535) m_errs_odd++;
        m_valid = 1'b0;
      end
    end else if (frame_clr) begin
      m_bits.delete();
    end else if (in_valid) begin
      if (m_bits.size() < 8) begin
        m_bits.push_back(in_bit);
      end else begin
        int ones;
        ones = int'(in_bit);
        for (int i = 0; i < 8; i++) begin
          m_data[i] = m_bits[i];
          ones += int'(m_bits[i]);
        end
        m_ok_even = (ones % 2) == 0;
        m_ok_odd  = (ones % 2) == 1;
        m_valid   = 1'b1;
        m_bits.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid",     out_valid,     m_valid);
      check("in_ready",      in_ready,      !m_valid);
      check("out_data",      out_data,      m_data);
      check("out_ok",        out_ok,        m_ok_even);
      check("out_valid_odd", out_valid_odd, m_valid);
      check("out_data_odd",  out_data_odd,  m_data);
      check("out_ok_odd",    out_ok_odd,    m_ok_odd);
`ifdef PARITY_ERR_COUNT_EN
      check("err_count",     err_count,     m_errs_even[15:0]);
      check("err_count_odd", err_count_odd, m_errs_odd[15:0]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_bit   = word[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] word, input logic parity);
    send_bits(word, 8);
    in_valid = 1'b1;
    in_bit   = parity;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_ok",    out_ok,    0);
    check("rst_in_ready",  in_ready,  1);
    rst_n = 1'b1;
    tick();

    // A5, even parity bit 0: four ones -> good.
    send_frame(8'hA5, 1'b0);
    check("a5_valid", out_valid, 1);
    check("a5_data",  out_data,  8'hA5);
    check("a5_ok",    out_ok,    1);
    check("a5_ready", in_ready,  0);
    tick();
    check("a5_drop",  out_valid, 0);
    check("a5_rdy",   in_ready,  1);

    // 07, parity 0: three ones -> bad.
    send_frame(8'h07, 1'b0);
    check("07_data", out_data, 8'h07);
    check("07_ok",   out_ok,   0);
    tick();
`ifdef PARITY_ERR_COUNT_EN
    check("07_errcnt", err_count, 1);
`endif

    // Hold with downstream stalled; beats offered meanwhile are ignored.
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_data",  out_data,  8'h3C);
      check("hold_ok",    out_ok,    1);
      check("hold_ready", in_ready,  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("hold_release", out_valid, 0);
    send_frame(8'h5A, 1'b0);
    check("after_hold_data", out_data, 8'h5A);
    check("after_hold_ok",   out_ok,   1);
    tick();

    // Abort after 4 bits (clear coincides with a beat), then a full frame.
    send_bits(8'h0F, 4);
    frame_clr = 1'b1;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    tick();
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    check("clr_no_result", out_valid, 0);
    send_frame(8'hFF, 1'b0);
    check("clr_data", out_data, 8'hFF);
    check("clr_ok",   out_ok,   1);
    tick();
    check("clr_single", out_valid, 0);

    // Asynchronous reset mid-frame.
    send_bits(8'h05, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data",  out_data,  0);
    check("arst_valid", out_valid, 0);
    check("arst_ok",    out_ok,    0);
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h81, 1'b0);
    check("post_rst_data", out_data, 8'h81);
    check("post_rst_ok",   out_ok,   1);
    tick();

    // Odd-parity instance.
    send_frame(8'h01, 1'b0);
    check("odd_01_p0_ok", out_ok_odd, 1);
    check("even_01_p0_ok", out_ok, 0);
    tick();
    send_frame(8'h01, 1'b1);
    check("odd_01_p1_ok", out_ok_odd, 0);
    check("even_01_p1_ok", out_ok, 1);
    tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      frame_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid  = 1'b0;
    frame_clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
